fire9_ex_1_drain: RTL

- Downstream neighbour of the fire9 1x1 expand stage.
- Captures each 368-channel parallel output vector (one per 8x8 pixel position) on the expand stage's sample strobe.
- Double-buffers the vectors and streams them channel-serial, one 16-bit value per cycle, with a valid/ready handshake to the next layer's input feeder.
- Tracks pixel/channel position, flags overflow, and signals layer completion after 64 pixels.

---
 rtl/fire9_pkg.sv | 15 +
 rtl/fire9_ex_1_drain_if.sv | 25 ++
 rtl/drain_bank.sv | 20 ++
 rtl/fire9_ex_1_drain.sv | 87 ++++++++
 4 files changed

// File: rtl/fire9_pkg.sv
// Shared types and dimensions for the fire9 expand-stage drain.
// The 368-channel vector type matches the expand stage's parallel output.
package fire9_pkg;
  localparam int WIDTH  = 16;
  localparam int CHOUT  = 368;
  localparam int W_IN   = 8;
  localparam int PIXELS = W_IN * W_IN;
  localparam int CH_W   = $clog2(CHOUT);
  localparam int PIX_W  = $clog2(PIXELS);

  typedef logic [15:0] pix_t;
  typedef pix_t vec_t [0:CHOUT-1];
  typedef logic [CH_W-1:0]  ch_idx_t;
  typedef logic [PIX_W-1:0] pix_idx_t;
endpackage

// File: rtl/fire9_ex_1_drain_if.sv
// Capture bus from the expand stage and serial output stream to the next layer.
// The master modport is the drain's own view; the slave modport is its neighbours' view.
interface fire9_ex_1_drain_if;
  import fire9_pkg::*;

  logic     vec_valid;
  vec_t     vec_in;
  logic     vec_ready;
  pix_t     ofm_data;
  logic     ofm_valid;
  logic     ofm_ready;
  ch_idx_t  ofm_ch;
  pix_idx_t ofm_pix;
  logic     ofm_last;

  modport master (
    input  vec_valid, vec_in, ofm_ready,
    output vec_ready, ofm_data, ofm_valid, ofm_ch, ofm_pix, ofm_last
  );

  modport slave (
    output vec_valid, vec_in, ofm_ready,
    input  vec_ready, ofm_data, ofm_valid, ofm_ch, ofm_pix, ofm_last
  );
endinterface

// File: rtl/drain_bank.sv
// One CHOUT x WIDTH vector register bank: whole-vector write, indexed combinational read.
module drain_bank
  import fire9_pkg::*;
(
  input  logic    clk,
  input  logic    we,
  input  vec_t    wdata,
  input  ch_idx_t rd_idx,
  output pix_t    rdata
);
  vec_t mem;

  // NOTE: the bank is deliberately not reset; it is only read while its full flag
  // is set, which always follows a write, so a reset would only cost a huge fan-out.
  always_ff @(posedge clk) begin
    if (we) mem <= wdata;
  end

  assign rdata = mem[rd_idx];
endmodule

// File: rtl/fire9_ex_1_drain.sv
// Double-buffered drain: captures 368-channel vectors and streams them channel-serial,
// tracking pixel/channel position, overflow and layer completion.
module fire9_ex_1_drain
  import fire9_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  fire9_ex_1_drain_if.master bus,
  output logic               overflow,
  output logic               layer_done
);
  logic [1:0] full, full_d, we;
  logic       wr_bank, rd_bank;
  ch_idx_t    rd_ch;
  pix_idx_t   pix_cnt;
  pix_t       rdata [2];
  logic       capture, drop, hs, last_ch, rel;

  // vec_ready looks only at the current flags: a bank freed on this edge is not reusable until next cycle.
  assign bus.vec_ready = ~&full;
  assign bus.ofm_valid = full[rd_bank];
  assign hs            = bus.ofm_valid & bus.ofm_ready;
  assign last_ch       = (rd_ch == ch_idx_t'(CHOUT - 1));
  assign rel           = hs & last_ch;
  assign capture       = bus.vec_valid &  bus.vec_ready & ~layer_done & ~start;
  assign drop          = bus.vec_valid & ~bus.vec_ready & ~layer_done & ~start;
  assign we            = capture ? (wr_bank ? 2'b10 : 2'b01) : 2'b00;

  for (genvar b = 0; b < 2; b++) begin : g_bank
    drain_bank u_bank (
      .clk    (clk),
      .we     (we[b]),
      .wdata  (bus.vec_in),
      .rd_idx (rd_ch),
      .rdata  (rdata[b])
    );
  end

  // NOTE: full_d starts from its current value so every path assigns it and no latch is inferred.
  always_comb begin
    full_d = full;
    if (rel)     full_d[rd_bank] = 1'b0;
    if (capture) full_d[wr_bank] = 1'b1;
  end

  // Data is gated so the stream reads zero whenever nothing is buffered, including during reset.
  assign bus.ofm_data = bus.ofm_valid ? rdata[rd_bank] : '0;
  assign bus.ofm_ch   = rd_ch;
  assign bus.ofm_pix  = pix_cnt;
  assign bus.ofm_last = bus.ofm_valid & last_ch & (pix_cnt == pix_idx_t'(PIXELS - 1));

  // NOTE: non-blocking assignments let every register see pre-edge values, so capture and release on one edge compose.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      full       <= '0;
      wr_bank    <= 1'b0;
      rd_bank    <= 1'b0;
      rd_ch      <= '0;
      pix_cnt    <= '0;
      overflow   <= 1'b0;
      layer_done <= 1'b0;
    end else if (start) begin
      full       <= '0;
      wr_bank    <= 1'b0;
      rd_bank    <= 1'b0;
      rd_ch      <= '0;
      pix_cnt    <= '0;
      overflow   <= 1'b0;
      layer_done <= 1'b0;
    end else begin
      full <= full_d;
      if (capture) wr_bank <= ~wr_bank;
      if (hs) begin
        if (last_ch) begin
          rd_ch   <= '0;
          rd_bank <= ~rd_bank;
          pix_cnt <= pix_cnt + 1'b1;
        end else begin
          rd_ch <= rd_ch + 1'b1;
        end
      end
      if (drop) overflow <= 1'b1;
      if (hs && bus.ofm_last) layer_done <= 1'b1;
    end
  end
endmodule
